// File: rtl/uart_pkg.sv
// Shared types and helpers for the self-test UART.
// Optional feature macro: UART_PARITY_EN (adds one even-parity bit per frame).
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Clocks per bit period from clock frequency and line rate.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clocks from the start edge to the middle of the start bit.
    function automatic int half_bit_clks(input int cpb);
        return cpb / 2;
    endfunction

    localparam int DEFAULT_CLKS_PER_BIT = 50_000_000 / 115_200;

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, shift register
// and a held output byte that only updates on a good frame.
// Optional feature macro: UART_PARITY_EN (checks even parity before accepting).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data
);

    localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF_BIT  = half_bit_clks(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    logic             sync1_r, sync2_r;
    logic             rx_s;
    rx_state_t        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_r, bit_n;
    logic [7:0]       shift_r, shift_n;
    logic [7:0]       data_r, data_n;
    logic             frame_ok_s;

`ifdef UART_PARITY_EN
    logic par_r, par_n;
    assign frame_ok_s = (par_r == even_parity(shift_r));
`else
    assign frame_ok_s = 1'b1;
`endif

    assign rx_s = sync2_r;
    assign data = data_r;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Receive FSM next-state: find start edge, qualify at mid-bit, sample bits.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r + CNT_W'(1);
        bit_n   = bit_r;
        shift_n = shift_r;
        data_n  = data_r;
`ifdef UART_PARITY_EN
        par_n   = par_r;
`endif
        case (state_r)
            RX_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = RX_START;
                end else begin
                    state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n = '0;
                    bit_n = 3'd0;
                    // A line already high again at mid-start was only a glitch.
                    if (rx_s) begin
                        state_n = RX_IDLE;
                    end else begin
                        state_n = RX_DATA;
                    end
                end else begin
                    state_n = RX_START;
                end
            end
            RX_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = RX_PARITY;
`else
                        state_n = RX_STOP;
`endif
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end else begin
                    state_n = RX_DATA;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = RX_STOP;
                end else begin
                    state_n = RX_PARITY;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    cnt_n   = '0;
                    state_n = RX_IDLE;
                    if (rx_s && frame_ok_s) begin
                        data_n = shift_r;
                    end else begin
                        data_n = data_r;
                    end
                end else begin
                    state_n = RX_STOP;
                end
            end
            default: begin
                state_n = RX_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Receive state, counters and output byte; reset discards any partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RX_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
`ifdef UART_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            data_r  <= data_n;
`ifdef UART_PARITY_EN
            par_r   <= par_n;
`endif
        end
    end

endmodule

// File: rtl/uart_module.sv
// Self-test UART: incrementing-byte transmitter plus receiver. With Tx looped
// to Rx, data follows tx_data one frame later.
// Optional feature macro: UART_PARITY_EN (even-parity bit after bit 7).
module uart_module #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = uart_pkg::clks_per_bit(CLK_FREQ, BAUD),
    parameter int GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    output logic       Tx,
    output logic [7:0] tx_data,
    output logic [7:0] data
);
    import uart_pkg::*;

    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int CNT_MAX  = (GAP_CLKS > CLKS_PER_BIT) ? GAP_CLKS : CLKS_PER_BIT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLKS - 1);

    tx_state_t        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_r, bit_n;
    logic [7:0]       tx_data_r, tx_data_n;
    logic             tx_r, tx_n;

    assign Tx      = tx_r;
    assign tx_data = tx_data_r;

    // Transmit FSM next-state; the line level is derived from the next state
    // so the registered Tx lines up exactly with the state register.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r + CNT_W'(1);
        bit_n     = bit_r;
        tx_data_n = tx_data_r;
        tx_n      = 1'b1;
        case (state_r)
            TX_IDLE: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = TX_START;
                end else begin
                    state_n = TX_IDLE;
                end
            end
            TX_START: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    state_n = TX_DATA;
                end else begin
                    state_n = TX_START;
                end
            end
            TX_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n = '0;
                    if (bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = TX_PARITY;
`else
                        state_n = TX_STOP;
`endif
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end else begin
                    state_n = TX_DATA;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = TX_STOP;
                end else begin
                    state_n = TX_PARITY;
                end
            end
`endif
            TX_STOP: begin
                if (cnt_r == BIT_LAST) begin
                    // Advance the pattern only after the frame is fully sent.
                    cnt_n     = '0;
                    tx_data_n = tx_data_r + 8'd1;
                    state_n   = TX_IDLE;
                end else begin
                    state_n = TX_STOP;
                end
            end
            default: begin
                state_n = TX_IDLE;
                cnt_n   = '0;
            end
        endcase

        case (state_n)
            TX_START:  tx_n = 1'b0;
            TX_DATA:   tx_n = tx_data_r[bit_n];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_n = even_parity(tx_data_r);
`endif
            default:   tx_n = 1'b1;
        endcase
    end

    // Transmit state and outputs; reset forces the line high on the next clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= TX_IDLE;
            cnt_r     <= '0;
            bit_r     <= 3'd0;
            tx_data_r <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            bit_r     <= bit_n;
            tx_data_r <= tx_data_n;
            tx_r      <= tx_n;
        end
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk  (clk),
        .rst  (rst),
        .rx   (Rx),
        .data (data)
    );

endmodule

// File: tb/tb_uart_module.sv
// Scoreboard bench for uart_module with a shortened bit period.
module tb_uart_module;

    localparam int CPB  = 10;
    localparam int GAP  = 2;
    localparam int HALF = CPB / 2;
    localparam int N    = GAP * CPB;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int P   = (FB + GAP) * CPB;
    localparam int LAT = 2 + HALF + (FB - 1) * CPB;

    localparam int SEL_TX = 0;
    localparam int SEL_TXD = 1;
    localparam int SEL_DATA = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       loop;
    logic       rx_drv;
    logic       rx_line;
    logic       Tx;
    logic [7:0] tx_data;
    logic [7:0] data;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        string      name;
        int         sel;
        bit         hold;
        logic [7:0] exp;
        int         lo;
        int         hi;
    } item_t;

    item_t sb[$];

    assign rx_line = loop ? Tx : rx_drv;

    uart_module #(
        .CLK_FREQ    (1_152_000),
        .BAUD        (115200),
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GAP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .Rx     (rx_line),
        .Tx     (Tx),
        .tx_data(tx_data),
        .data   (data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pick(input int sel);
        if (sel == SEL_TX) return {7'd0, Tx};
        else if (sel == SEL_TXD) return tx_data;
        else return data;
    endfunction

    // Line level of bit b (0 = start) of a frame carrying v.
    function automatic logic fbit(input logic [7:0] v, input int b, input logic flip);
        if (b == 0) return 1'b0;
        else if (b <= 8) return v[b-1];
        else if (FB == 11 && b == 9) return (^v) ^ flip;
        else return 1'b1;
    endfunction

    task automatic push(input string name, input int sel, input bit hold,
                        input logic [7:0] exp, input int lo, input int hi);
        item_t it;
        it.name = name; it.sel = sel; it.hold = hold;
        it.exp = exp; it.lo = lo; it.hi = hi;
        sb.push_back(it);
    endtask

    task automatic push_frame_tx(input int s, input logic [7:0] v);
        for (int b = 0; b < FB; b++)
            push($sformatf("tx_bit%0d_of_%02h", b, v), SEL_TX, 1'b1,
                 {7'd0, fbit(v, b, 1'b0)}, s + b * CPB, s + b * CPB + CPB - 1);
        push($sformatf("tx_data_stable_%02h", v), SEL_TXD, 1'b1, v, s, s + FB * CPB - 1);
    endtask

    task automatic push_rx(input int s, input logic [7:0] v, input logic [7:0] prev);
        push($sformatf("rx_not_early_%02h", v), SEL_DATA, 1'b1, prev, s + LAT - 3, s + LAT - 3);
        push($sformatf("rx_data_%02h", v), SEL_DATA, 1'b0, v, s + LAT - 2, s + LAT + 2);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic stop, input logic flip);
        for (int b = 0; b < FB; b++) begin
            rx_drv = (b == FB - 1) ? stop : fbit(v, b, flip);
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    // Monitor: resolve every scoreboard item whose window the run has reached.
    initial begin
        item_t      it;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                it = sb[i];
                if (cyc >= it.lo) begin
                    act = pick(it.sel);
                    if (act == it.exp) begin
                        if (!it.hold || cyc >= it.hi) begin
                            n_pass++;
                            n_total++;
                            sb.delete(i);
                        end
                    end else if (it.hold || cyc >= it.hi) begin
                        $display("FAIL %s: got %02h expected %02h at cycle %0d",
                                 it.name, act, it.exp, cyc);
                        n_total++;
                        sb.delete(i);
                    end
                end
            end
        end
    end

    // Stimulus: pushes expectations ahead of time, then drives the run.
    initial begin
        int r, s, c;
        logic [7:0] v, pv;
        rst = 1'b1; loop = 1'b1; rx_drv = 1'b1;

        // Reset and loopback of the first four frames.
        repeat (4) @(negedge clk);
        push("reset_tx", SEL_TX, 1'b1, 8'h01, cyc + 1, cyc + 1);
        push("reset_tx_data", SEL_TXD, 1'b1, 8'h00, cyc + 1, cyc + 1);
        push("reset_data", SEL_DATA, 1'b1, 8'h00, cyc + 1, cyc + 1);
        r = cyc + 1;
        push("tx_idle_after_reset", SEL_TX, 1'b1, 8'h01, r, r + N - 1);
        @(negedge clk);
        rst = 1'b0;
        push_frame_tx(r + N, 8'h00);
        push_frame_tx(r + N + P, 8'h01);
        for (int k = 0; k < 4; k++) begin
            v = 8'(k);
            pv = (k == 0) ? 8'h00 : 8'(k - 1);
            push_rx(r + N + k * P, v, pv);
        end
        while (cyc < r + N + 3 * P + LAT + 5) @(negedge clk);
        loop = 1'b0;

        // Direct drive: glitch, good frame, framing error, parity error.
        push("glitch_ignored", SEL_DATA, 1'b1, 8'h03, cyc + 1, cyc + 12 * CPB);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        push_rx(cyc, 8'hA5, 8'h03);
        send_byte(8'hA5, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        push("bad_stop_ignored", SEL_DATA, 1'b1, 8'hA5, cyc + 1, cyc + FB * CPB + 3 * CPB);
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (3 * CPB) @(negedge clk);
`ifdef UART_PARITY_EN
        push("bad_parity_ignored", SEL_DATA, 1'b1, 8'hA5, cyc + 1, cyc + FB * CPB + 3 * CPB);
        send_byte(8'h5A, 1'b1, 1'b1);
        repeat (3 * CPB) @(negedge clk);
`endif

        // Fresh reset, then reset again during bit 4 of the third frame.
        rst = 1'b1;
        loop = 1'b1;
        repeat (5) @(negedge clk);
        r = cyc + 1;
        @(negedge clk);
        rst = 1'b0;
        c = r + N + 2 * P + 5 * CPB + 3;
        while (cyc < c - 1) @(negedge clk);
        push("tx_bit4_of_02", SEL_TX, 1'b1, 8'h00, c, c);
        @(negedge clk);
        push("midframe_reset_tx", SEL_TX, 1'b1, 8'h01, cyc + 1, cyc + 1);
        push("midframe_reset_tx_data", SEL_TXD, 1'b1, 8'h00, cyc + 1, cyc + 1);
        push("midframe_reset_data", SEL_DATA, 1'b1, 8'h00, cyc + 1, cyc + 1);
        rst = 1'b1;
        @(negedge clk);
        r = cyc + 1;
        @(negedge clk);
        rst = 1'b0;

        // 257 looped frames: tx_data and data wrap 0xFF -> 0x00.
        for (int k = 0; k <= 256; k++) begin
            s = r + N + k * P;
            while (cyc < s - 2) @(negedge clk);
            v = 8'(k);
            pv = (k == 0) ? 8'h00 : 8'(k - 1);
            push($sformatf("wrap_tx_data_%0d", k), SEL_TXD, 1'b1, v, s, s + FB * CPB - 1);
            push_rx(s, v, pv);
        end

        for (int w = 0; w < 3000 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            foreach (sb[i]) begin
                $display("FAIL %s: got unresolved expected %02h by cycle %0d",
                         sb[i].name, sb[i].exp, cyc);
                n_total++;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
